frame_tx: RTL and testbench

//  Drains frame bytes from an upstream fifo (read side) and serialises them onto a

---
 rtl/eth_pkg.sv | 25 ++
 rtl/frame_tx.sv | 130 +++++++++++++
 tb/tb_frame_tx.sv | 260 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/eth_pkg.sv
// Shared types and constants for the byte-wide frame transmit path.
package eth_pkg;

  localparam int unsigned DATA_W  = 8;
  localparam int unsigned LEN_W   = 11;
  localparam int unsigned PRE_LEN = 7;
  localparam int unsigned IFG_LEN = 12;

  localparam logic [7:0] PREAMBLE_BYTE = 8'h55;
  localparam logic [7:0] SFD_BYTE      = 8'hD5;

  // One counter serves both the preamble and the inter-frame gap.
  localparam int unsigned GAP_MAX = (PRE_LEN > IFG_LEN) ? PRE_LEN : IFG_LEN;
  localparam int unsigned GAP_W   = $clog2(GAP_MAX + 1);

  typedef enum logic [2:0] {
    IDLE,
    PRE,
    SFD,
    DATA,
    ABORT,
    IFG
  } tx_state_t;

endpackage

// File: rtl/frame_tx.sv
// Drains a frame from the egress fifo onto a byte-wide transmit interface:
// preamble, SFD, payload, inter-frame gap; aborts with tx_er on fifo underrun.
module frame_tx
  import eth_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [LEN_W-1:0]  len,
  output logic              busy,
  output logic              fifo_rd_en,
  input  logic [DATA_W-1:0] fifo_rd_data,
  input  logic              fifo_empty,
  output logic              tx_en,
  output logic              tx_er,
  output logic [DATA_W-1:0] txd,
  output logic              done,
  output logic              underrun
);

  tx_state_t         state, state_n;
  logic [GAP_W-1:0]  gap_cnt, gap_cnt_n;
  logic [LEN_W-1:0]  byte_cnt, byte_cnt_n;
  logic [LEN_W-1:0]  pop_cnt, pop_cnt_n;
  logic              miss_c, miss_q;
  logic              pop_start_c;
  logic              rd_en_n, busy_n, tx_en_n, tx_er_n, done_n, underrun_n;
  logic [DATA_W-1:0] txd_n;

  // A pop issued while empty is seen on the wire two cycles later.
  assign miss_c = fifo_rd_en && fifo_empty;

  // Next state, counters and the registered output values.
  always_comb begin
    state_n     = state;
    gap_cnt_n   = gap_cnt;
    byte_cnt_n  = byte_cnt;
    pop_cnt_n   = pop_cnt;
    pop_start_c = 1'b0;

    case (state)
      IDLE: begin
        if (start && (len != '0)) begin
          state_n     = PRE;
          gap_cnt_n   = GAP_W'(PRE_LEN - 1);
          byte_cnt_n  = len;
          pop_cnt_n   = len;
          pop_start_c = (PRE_LEN == 1);
        end
      end
      PRE: begin
        pop_start_c = (gap_cnt == GAP_W'(1));
        if (gap_cnt == '0) state_n = SFD;
        else               gap_cnt_n = gap_cnt - GAP_W'(1);
      end
      SFD: begin
        state_n = miss_q ? ABORT : DATA;
        if (miss_q) gap_cnt_n = GAP_W'(IFG_LEN - 1);
      end
      DATA: begin
        if (miss_q) begin
          state_n = ABORT;
        end else if (byte_cnt == LEN_W'(1)) begin
          state_n   = IFG;
          gap_cnt_n = GAP_W'(IFG_LEN - 1);
        end else begin
          byte_cnt_n = byte_cnt - LEN_W'(1);
        end
      end
      ABORT: begin
        state_n   = IFG;
        gap_cnt_n = GAP_W'(IFG_LEN - 1);
      end
      IFG: begin
        if (gap_cnt == '0) state_n = IDLE;
        else               gap_cnt_n = gap_cnt - GAP_W'(1);
      end
      default: state_n = IDLE;
    endcase

    // Pops run ahead of the wire by the fifo latency plus the output register.
    if (fifo_rd_en) pop_cnt_n = pop_cnt - LEN_W'(1);
    rd_en_n = (pop_start_c || fifo_rd_en) && (pop_cnt_n != '0) && !miss_c;

    busy_n     = (state_n != IDLE);
    tx_en_n    = (state_n inside {PRE, SFD, DATA, ABORT});
    tx_er_n    = (state_n == ABORT);
    underrun_n = (state_n == ABORT);
    done_n     = (state == DATA) && (state_n == IFG);

    case (state_n)
      PRE:     txd_n = DATA_W'(PREAMBLE_BYTE);
      SFD:     txd_n = DATA_W'(SFD_BYTE);
      DATA:    txd_n = fifo_rd_data;
      default: txd_n = '0;
    endcase
  end

  // State, counters and all outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      gap_cnt    <= '0;
      byte_cnt   <= '0;
      pop_cnt    <= '0;
      miss_q     <= 1'b0;
      busy       <= 1'b0;
      fifo_rd_en <= 1'b0;
      tx_en      <= 1'b0;
      tx_er      <= 1'b0;
      txd        <= '0;
      done       <= 1'b0;
      underrun   <= 1'b0;
    end else begin
      state      <= state_n;
      gap_cnt    <= gap_cnt_n;
      byte_cnt   <= byte_cnt_n;
      pop_cnt    <= pop_cnt_n;
      miss_q     <= miss_c;
      busy       <= busy_n;
      fifo_rd_en <= rd_en_n;
      tx_en      <= tx_en_n;
      tx_er      <= tx_er_n;
      txd        <= txd_n;
      done       <= done_n;
      underrun   <= underrun_n;
    end
  end

endmodule

// File: tb/tb_frame_tx.sv
// Bench for frame_tx: behavioural fifo, wire-byte scoreboard and per-scenario timing checks.
module tb_frame_tx;
  import eth_pkg::*;

  logic              clk = 1'b0;
  logic              rst;
  logic              start;
  logic [LEN_W-1:0]  len;
  logic              busy;
  logic              fifo_rd_en;
  logic [DATA_W-1:0] fifo_rd_data;
  logic              fifo_empty;
  logic              tx_en;
  logic              tx_er;
  logic [DATA_W-1:0] txd;
  logic              done;
  logic              underrun;

  frame_tx dut (
    .clk(clk), .rst(rst), .start(start), .len(len), .busy(busy),
    .fifo_rd_en(fifo_rd_en), .fifo_rd_data(fifo_rd_data), .fifo_empty(fifo_empty),
    .tx_en(tx_en), .tx_er(tx_er), .txd(txd), .done(done), .underrun(underrun)
  );

  always #5 clk = ~clk;

  logic [7:0] fq[$];
  logic [7:0] exq[$];
  int cyc_n, n_checks, n_fail;
  int n_pops, n_done, n_under, n_er, pop_first, done_cyc, under_cyc, er_cyc, last_tx, rise_cyc;
  logic prev_tx_en;

  task automatic clr_stats();
    n_pops = 0; n_done = 0; n_under = 0; n_er = 0;
    pop_first = -1; done_cyc = -1; under_cyc = -1; er_cyc = -1; last_tx = -1; rise_cyc = -1;
  endtask

  // Wire scoreboard and event bookkeeping for the cycle just entered.
  task automatic monitor();
    logic [7:0] exp_b;
    if (fifo_rd_en === 1'b1) begin
      if (n_pops == 0) pop_first = cyc_n;
      n_pops++;
    end
    if (done === 1'b1) begin n_done++; done_cyc = cyc_n; end
    if (underrun === 1'b1) begin n_under++; under_cyc = cyc_n; end
    if (tx_en === 1'b1) begin
      last_tx = cyc_n;
      if (prev_tx_en !== 1'b1) rise_cyc = cyc_n;
    end
    prev_tx_en = tx_en;
    n_checks++;
    if (tx_en === 1'b1 && tx_er === 1'b1) begin
      n_er++; er_cyc = cyc_n;
      if (txd !== 8'h00) begin
        n_fail++; $display("FAIL abort_txd cycle %0d got=%02h exp=00", cyc_n, txd);
      end
    end else if (tx_en === 1'b1) begin
      if (exq.size() == 0) begin
        n_fail++; $display("FAIL wire_byte cycle %0d got=%02h exp=none", cyc_n, txd);
      end else begin
        exp_b = exq.pop_front();
        if (txd !== exp_b) begin
          n_fail++; $display("FAIL wire_byte cycle %0d got=%02h exp=%02h", cyc_n, txd, exp_b);
        end
      end
    end else if (tx_er !== 1'b0 || txd !== 8'h00) begin
      n_fail++; $display("FAIL idle_wire cycle %0d got er=%b txd=%02h exp er=0 txd=00", cyc_n, tx_er, txd);
    end
  endtask

  // One clock: fifo model pops on a read while non-empty, data valid next cycle.
  task automatic cyc();
    logic pop;
    pop = (fifo_rd_en === 1'b1) && (fq.size() != 0);
    @(posedge clk);
    #1;
    if (pop) fifo_rd_data = fq.pop_front();
    fifo_empty = (fq.size() == 0);
    cyc_n++;
    monitor();
  endtask

  task automatic expect_hdr();
    for (int i = 0; i < int'(PRE_LEN); i++) exq.push_back(PREAMBLE_BYTE);
    exq.push_back(SFD_BYTE);
  endtask

  task automatic push_byte(input logic [7:0] b, input bit on_wire);
    fq.push_back(b);
    if (on_wire) exq.push_back(b);
    fifo_empty = 1'b0;
  endtask

  task automatic accept(input int n, output int a);
    start = 1'b1;
    len   = LEN_W'(n);
    a     = cyc_n;
    cyc();
    start = 1'b0;
  endtask

  task automatic wait_idle(input int budget, output int fall);
    fall = -1;
    for (int i = 0; i < budget; i++) begin
      if (busy === 1'b0) begin fall = cyc_n; break; end
      cyc();
    end
    if (fall < 0) begin
      n_checks++; n_fail++;
      $display("FAIL wait_idle timeout got busy=%b exp=0 within %0d cycles", busy, budget);
    end
  endtask

  task automatic test_reset();
    int a;
    n_checks++;
    if ({busy, fifo_rd_en, tx_en, tx_er, done, underrun, txd} !== 14'd0) begin
      n_fail++; $display("FAIL reset_outputs got=%04h exp=0000", {busy, fifo_rd_en, tx_en, tx_er, done, underrun, txd});
    end
    cyc();
    rst = 1'b0;
    cyc();
    clr_stats();
    expect_hdr();
    for (int i = 0; i < 64; i++) push_byte(8'(i + 8'h40), 1'b1);
    accept(64, a);
    while (cyc_n < a + 14) cyc();
    n_checks++;
    if ({busy, fifo_rd_en, tx_en} !== 3'b111) begin
      n_fail++; $display("FAIL mid_frame_active got=%b exp=111", {busy, fifo_rd_en, tx_en});
    end
    rst = 1'b1;
    #1;
    n_checks++;
    if ({busy, fifo_rd_en, tx_en, tx_er, done, underrun, txd} !== 14'd0) begin
      n_fail++; $display("FAIL reset_async got=%04h exp=0000", {busy, fifo_rd_en, tx_en, tx_er, done, underrun, txd});
    end
    cyc();
    n_checks++;
    if ({busy, fifo_rd_en, tx_en, tx_er, done, underrun, txd} !== 14'd0) begin
      n_fail++; $display("FAIL reset_hold got=%04h exp=0000", {busy, fifo_rd_en, tx_en, tx_er, done, underrun, txd});
    end
    rst = 1'b0;
    fq.delete();
    exq.delete();
    fifo_empty = 1'b1;
    repeat (3) cyc();
    n_checks++;
    if ({busy, fifo_rd_en, tx_en} !== 3'b000) begin
      n_fail++; $display("FAIL reset_release got=%b exp=000", {busy, fifo_rd_en, tx_en});
    end
  endtask

  task automatic test_basic();
    int a, fall;
    clr_stats();
    expect_hdr();
    for (int i = 1; i <= 4; i++) push_byte(8'(i), 1'b1);
    accept(4, a);
    wait_idle(100, fall);
    n_checks++; if (pop_first !== a + 7) begin n_fail++; $display("FAIL basic_pop_first got=%0d exp=%0d", pop_first, a + 7); end
    n_checks++; if (n_pops !== 4) begin n_fail++; $display("FAIL basic_pops got=%0d exp=4", n_pops); end
    n_checks++; if (done_cyc !== a + 13 || n_done !== 1) begin n_fail++; $display("FAIL basic_done got=%0d/%0d exp=%0d/1", done_cyc, n_done, a + 13); end
    n_checks++; if (last_tx !== a + 12 || n_under !== 0) begin n_fail++; $display("FAIL basic_last_tx got=%0d/%0d exp=%0d/0", last_tx, n_under, a + 12); end
    n_checks++; if (fall !== a + 25) begin n_fail++; $display("FAIL basic_busy_fall got=%0d exp=%0d", fall, a + 25); end
    n_checks++; if (exq.size() !== 0) begin n_fail++; $display("FAIL basic_scoreboard got=%0d left exp=0", exq.size()); end
  endtask

  task automatic test_len1();
    int a, fall;
    clr_stats();
    expect_hdr();
    push_byte(8'hA5, 1'b1);
    accept(1, a);
    wait_idle(100, fall);
    n_checks++; if (pop_first !== a + 7 || n_pops !== 1) begin n_fail++; $display("FAIL len1_pop got=%0d/%0d exp=%0d/1", pop_first, n_pops, a + 7); end
    n_checks++; if (done_cyc !== a + 10) begin n_fail++; $display("FAIL len1_done got=%0d exp=%0d", done_cyc, a + 10); end
    n_checks++; if (last_tx !== a + 9) begin n_fail++; $display("FAIL len1_last_tx got=%0d exp=%0d", last_tx, a + 9); end
    n_checks++; if (fall !== a + 22 || exq.size() !== 0) begin n_fail++; $display("FAIL len1_end got=%0d/%0d exp=%0d/0", fall, exq.size(), a + 22); end
  endtask

  task automatic test_underrun();
    int a, fall;
    clr_stats();
    expect_hdr();
    push_byte(8'h11, 1'b1);
    push_byte(8'h22, 1'b1);
    push_byte(8'h33, 1'b1);
    accept(6, a);
    wait_idle(100, fall);
    n_checks++; if (n_pops !== 4 || pop_first !== a + 7) begin n_fail++; $display("FAIL ur_pops got=%0d@%0d exp=4@%0d", n_pops, pop_first, a + 7); end
    n_checks++; if (er_cyc !== a + 12 || n_er !== 1) begin n_fail++; $display("FAIL ur_tx_er got=%0d/%0d exp=%0d/1", er_cyc, n_er, a + 12); end
    n_checks++; if (under_cyc !== a + 12 || n_under !== 1) begin n_fail++; $display("FAIL ur_pulse got=%0d/%0d exp=%0d/1", under_cyc, n_under, a + 12); end
    n_checks++; if (n_done !== 0) begin n_fail++; $display("FAIL ur_no_done got=%0d exp=0", n_done); end
    n_checks++; if (last_tx !== a + 12 || fall !== a + 25) begin n_fail++; $display("FAIL ur_ifg got=%0d/%0d exp=%0d/%0d", last_tx, fall, a + 12, a + 25); end
    n_checks++; if (exq.size() !== 0) begin n_fail++; $display("FAIL ur_scoreboard got=%0d left exp=0", exq.size()); end
  endtask

  task automatic test_back_to_back();
    int a1, fall;
    clr_stats();
    expect_hdr();
    push_byte(8'hC1, 1'b1);
    push_byte(8'hC2, 1'b1);
    expect_hdr();
    push_byte(8'hD1, 1'b1);
    push_byte(8'hD2, 1'b1);
    start = 1'b1;
    len   = LEN_W'(2);
    a1    = cyc_n;
    // Held start is refused through the last IFG cycle and taken in the IDLE cycle after it.
    while (cyc_n < a1 + 26) cyc();
    start = 1'b0;
    wait_idle(100, fall);
    n_checks++; if (rise_cyc !== a1 + 24) begin n_fail++; $display("FAIL b2b_second_pre got=%0d exp=%0d", rise_cyc, a1 + 24); end
    n_checks++; if (n_done !== 2 || n_pops !== 4) begin n_fail++; $display("FAIL b2b_counts got=%0d/%0d exp=2/4", n_done, n_pops); end
    n_checks++; if (fall !== a1 + 46) begin n_fail++; $display("FAIL b2b_busy_fall got=%0d exp=%0d", fall, a1 + 46); end
    n_checks++; if (exq.size() !== 0) begin n_fail++; $display("FAIL b2b_scoreboard got=%0d left exp=0", exq.size()); end
    clr_stats();
    start = 1'b1;
    len   = '0;
    repeat (6) cyc();
    start = 1'b0;
    n_checks++;
    if (n_pops !== 0 || last_tx !== -1 || busy !== 1'b0) begin
      n_fail++; $display("FAIL len0_ignored got pops=%0d tx=%0d busy=%b exp 0/-1/0", n_pops, last_tx, busy);
    end
  endtask

  task automatic test_max_len();
    int a, fall;
    clr_stats();
    expect_hdr();
    for (int i = 0; i < 2047; i++) push_byte(8'(i ^ (i >> 3)), 1'b1);
    accept(2047, a);
    wait_idle(2200, fall);
    n_checks++; if (n_pops !== 2047) begin n_fail++; $display("FAIL max_pops got=%0d exp=2047", n_pops); end
    n_checks++; if (done_cyc !== a + 9 + 2047 || n_under !== 0) begin n_fail++; $display("FAIL max_done got=%0d/%0d exp=%0d/0", done_cyc, n_under, a + 2056); end
    n_checks++; if (fall !== a + 9 + 2047 + 12) begin n_fail++; $display("FAIL max_busy_fall got=%0d exp=%0d", fall, a + 2068); end
    n_checks++; if (exq.size() !== 0) begin n_fail++; $display("FAIL max_scoreboard got=%0d left exp=0", exq.size()); end
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; len = '0;
    fifo_empty = 1'b1; fifo_rd_data = '0;
    cyc_n = 0; n_checks = 0; n_fail = 0; prev_tx_en = 1'b0;
    clr_stats();
    #2;
    test_reset();
    test_basic();
    test_len1();
    test_underrun();
    test_back_to_back();
    test_max_len();
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
